opc5ls_bus_responder: RTL and testbench

- Synthesizable bus-slave responder for the opc5ls CPU memory interface.
- Decodes vda/vpa/rnw/address from the CPU, serves reads and writes from on-chip RAM, and inserts wait states by driving clken.
- Contains a memory-mapped interval timer that raises the CPU interrupt line int_b.
- Replaces the behavioural memory and random-interrupt stimulus for FPGA builds and self-checking sims.

---
 rtl/opc5ls_bus_responder.sv | 169 ++++++++++++++++
 tb/tb_opc5ls_bus_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/opc5ls_bus_responder.sv
// Bus-slave responder for the opc5ls CPU: on-chip RAM with fixed wait states.
// Define RESP_IRQ_TIMER_EN to add the RELOAD/CTRL interval timer driving int_b.
module opc5ls_bus_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 1,
  parameter int TIMER_W     = 16
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        rnw,
  input  logic        vpa,
  input  logic        vda,
  output logic [15:0] rdata,
  output logic        clken,
  output logic        int_b
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t      state_q;
  logic [3:0]  wcnt_q;
  logic        mreq;
  logic        complete;
  logic        wr_en;
  logic        reg_hit;
  logic [15:0] reg_rd_d;
  logic        ram_we;
  logic [ADDR_W-1:0] ram_idx;

  logic [15:0] ram [2**ADDR_W];
  logic [15:0] ram_rd_q;
  logic        rd_valid_q;
  logic        rd_reg_sel_q;
  logic [15:0] rd_reg_q;

  // Upper address bits only matter for register decode; RAM aliases above ADDR_W.
  logic unused_addr;
  assign unused_addr = ^address;

  assign mreq     = vda | vpa;
  assign complete = (state_q == ST_WAIT) && (wcnt_q == 4'd0);
  assign wr_en    = complete && mreq && !rnw;
  assign ram_idx  = address[ADDR_W-1:0];
  assign ram_we   = wr_en && !reg_hit;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mreq) begin
            state_q <= ST_WAIT;
            wcnt_q  <= 4'(WAIT_STATES - 1);
          end
        end
        ST_WAIT: begin
          if (wcnt_q != 4'd0) begin
            wcnt_q <= wcnt_q - 4'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset forces clken high without waiting for a clock edge.
  always_comb begin
    clken = 1'b1;
    if (reset_b && (((state_q == ST_IDLE) && mreq) ||
                    ((state_q == ST_WAIT) && (wcnt_q != 4'd0)))) begin
      clken = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    ram_rd_q <= ram[ram_idx];
    if (ram_we) begin
      ram[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_valid_q   <= 1'b0;
      rd_reg_sel_q <= 1'b0;
      rd_reg_q     <= 16'h0000;
    end else begin
      rd_valid_q   <= 1'b1;
      rd_reg_sel_q <= reg_hit;
      rd_reg_q     <= reg_rd_d;
    end
  end

  assign rdata = !rd_valid_q ? 16'h0000 : (rd_reg_sel_q ? rd_reg_q : ram_rd_q);

`ifdef RESP_IRQ_TIMER_EN
  logic [TIMER_W-1:0] reload_q, reload_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic               enable_q, enable_d;
  logic               pending_q, pending_d;
  logic               hit_reload;
  logic               hit_ctrl;

  assign hit_reload = (address == 16'hFFFE);
  assign hit_ctrl   = (address == 16'hFFFF);
  assign reg_hit    = hit_reload || hit_ctrl;
  assign reg_rd_d   = hit_reload ? 16'(reload_q) : {14'b0, pending_q, enable_q};

  always_comb begin
    reload_d  = reload_q;
    count_d   = count_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    if (wr_en && hit_reload) begin
      reload_d = wdata[TIMER_W-1:0];
    end
    if (wr_en && hit_ctrl) begin
      enable_d = wdata[0];
      if (wdata[0] && !enable_q) begin
        count_d = reload_q;
      end
      if (wdata[1]) begin
        pending_d = 1'b0;
      end
    end
    // Applied after the CTRL write so an expiry beats a coincident clear.
    if (enable_q && (reload_q != '0)) begin
      if (count_q == TIMER_W'(1)) begin
        count_d   = reload_q;
        pending_d = 1'b1;
      end else if (count_q == '0) begin
        count_d = reload_q;
      end else begin
        count_d = count_q - TIMER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      reload_q  <= '0;
      count_q   <= '0;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      count_q   <= count_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
    end
  end

  assign int_b = !pending_q;
`else
  assign reg_hit  = 1'b0;
  assign reg_rd_d = 16'h0000;
  assign int_b    = 1'b1;
`endif

endmodule

// File: tb/tb_opc5ls_bus_responder.sv
// Directed self-checking bench for opc5ls_bus_responder with WAIT_STATES=2.
// Timer checks run when RESP_IRQ_TIMER_EN is defined, RAM-alias checks otherwise.
module tb_opc5ls_bus_responder;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] address = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        rnw = 1'b1;
  logic        vpa = 1'b0;
  logic        vda = 1'b0;
  logic [15:0] rdata;
  logic        clken;
  logic        int_b;

  int check_cnt = 0;
  int pass_cnt  = 0;
  bit int_low_seen = 1'b0;

  localparam logic [2:0] PAT = 3'b100; // clken 0,0,1 in sample order 0..2

  opc5ls_bus_responder #(.ADDR_W(12), .WAIT_STATES(2), .TIMER_W(16)) dut (
    .clk(clk), .reset_b(reset_b), .address(address), .wdata(wdata),
    .rnw(rnw), .vpa(vpa), .vda(vda), .rdata(rdata), .clken(clken), .int_b(int_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset_b && !int_b) int_low_seen = 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts at posedge+1; returns at posedge+1 after the completion cycle.
  task automatic access(input logic [15:0] a, input logic [15:0] d, input logic wr,
                        input logic fetch, output logic [15:0] rd, output logic [2:0] pat);
    address = a; wdata = d; rnw = !wr; vpa = fetch; vda = !fetch;
    rd = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat[i] = clken;
      if (i == 2) rd = rdata;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    vda = 1'b0; vpa = 1'b0; rnw = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] rd; logic [2:0] pat;
    access(a, d, 1'b1, 1'b0, rd, pat);
    idle();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] rd);
    logic [2:0] pat;
    access(a, 16'h0000, 1'b0, 1'b0, rd, pat);
    idle();
  endtask

  task automatic test_reset();
    reset_b = 1'b0; vda = 1'b1; address = 16'h0010;
    @(negedge clk);
    check_cnt++; if (clken !== 1'b1) $display("FAIL reset_clken: got %b want 1", clken); else pass_cnt++;
    check_cnt++; if (int_b !== 1'b1) $display("FAIL reset_int_b: got %b want 1", int_b); else pass_cnt++;
    check_cnt++; if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata); else pass_cnt++;
    idle();
    reset_b = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    logic [15:0] rd; logic [2:0] pat;
    bus_write(16'h0010, 16'h1234);
    access(16'h0010, 16'h0000, 1'b0, 1'b0, rd, pat);
    idle();
    check_cnt++; if (pat !== PAT) $display("FAIL read_clken: got %b want %b", pat, PAT); else pass_cnt++;
    check_cnt++; if (rd !== 16'h1234) $display("FAIL read_data: got %h want 1234", rd); else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic [2:0] pat;
    bus_write(16'h0021, 16'h1111);
    access(16'h0020, 16'hBEEF, 1'b1, 1'b0, rd, pat);
    idle();
    check_cnt++; if (pat !== PAT) $display("FAIL write_clken: got %b want %b", pat, PAT); else pass_cnt++;
    access(16'h0020, 16'h0000, 1'b0, 1'b0, rd, pat);
    idle();
    check_cnt++; if (pat !== PAT) $display("FAIL readback_clken: got %b want %b", pat, PAT); else pass_cnt++;
    check_cnt++; if (rd !== 16'hBEEF) $display("FAIL readback_data: got %h want beef", rd); else pass_cnt++;
    bus_read(16'h0021, rd);
    check_cnt++; if (rd !== 16'h1111) $display("FAIL neighbour_untouched: got %h want 1111", rd); else pass_cnt++;
    bus_read(16'h1020, rd);
    check_cnt++; if (rd !== 16'hBEEF) $display("FAIL alias_read: got %h want beef", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic [2:0] pat;
    for (int i = 0; i < 4; i++) bus_write(16'h0040 + 16'(i), 16'hC000 + 16'(i) * 16'h0101);
    for (int i = 0; i < 4; i++) begin
      access(16'h0040 + 16'(i), 16'h0000, 1'b0, 1'b1, rd, pat);
      check_cnt++; if (pat !== PAT) $display("FAIL fetch%0d_clken: got %b want %b", i, pat, PAT); else pass_cnt++;
      check_cnt++;
      if (rd !== 16'hC000 + 16'(i) * 16'h0101)
        $display("FAIL fetch%0d_data: got %h want %h", i, rd, 16'hC000 + 16'(i) * 16'h0101);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_mreq_drop();
    logic [15:0] rd; logic [2:0] pat;
    bus_write(16'h0050, 16'hAAAA);
    address = 16'h0050; wdata = 16'h5555; rnw = 1'b0; vda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat[i] = clken;
      @(posedge clk); #1;
      vda = 1'b0;
    end
    idle();
    check_cnt++; if (pat !== PAT) $display("FAIL drop_clken: got %b want %b", pat, PAT); else pass_cnt++;
    bus_read(16'h0050, rd);
    check_cnt++; if (rd !== 16'hAAAA) $display("FAIL drop_no_write: got %h want aaaa", rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd;
    bus_write(16'h0030, 16'h3333);
`ifdef RESP_IRQ_TIMER_EN
    bus_write(16'hFFFE, 16'h0009);
    bus_write(16'hFFFF, 16'h0001);
`endif
    address = 16'h0030; wdata = 16'hDEAD; rnw = 1'b0; vda = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset_b = 1'b0;
    #1;
    check_cnt++; if (clken !== 1'b1) $display("FAIL midreset_clken: got %b want 1", clken); else pass_cnt++;
    check_cnt++; if (int_b !== 1'b1) $display("FAIL midreset_int_b: got %b want 1", int_b); else pass_cnt++;
    idle();
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk); #1;
    bus_read(16'h0030, rd);
    check_cnt++; if (rd !== 16'h3333) $display("FAIL midreset_ram: got %h want 3333", rd); else pass_cnt++;
`ifdef RESP_IRQ_TIMER_EN
    bus_read(16'hFFFF, rd);
    check_cnt++; if (rd !== 16'h0000) $display("FAIL midreset_ctrl: got %h want 0000", rd); else pass_cnt++;
    bus_read(16'hFFFE, rd);
    check_cnt++; if (rd !== 16'h0000) $display("FAIL midreset_reload: got %h want 0000", rd); else pass_cnt++;
`endif
  endtask

`ifdef RESP_IRQ_TIMER_EN
  task automatic test_timer();
    logic [15:0] rd; logic [2:0] pat;
    int bad;
    bus_write(16'h0FFE, 16'h7777);
    bus_write(16'hFFFE, 16'h0005);
    bus_read(16'hFFFE, rd);
    check_cnt++; if (rd !== 16'h0005) $display("FAIL reload_read: got %h want 0005", rd); else pass_cnt++;
    bus_read(16'h0FFE, rd);
    check_cnt++; if (rd !== 16'h7777) $display("FAIL reg_no_ram: got %h want 7777", rd); else pass_cnt++;
    // Enabling write lands on posedge E; pending rises at E+5.
    bus_write(16'hFFFF, 16'h0001);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      check_cnt++;
      if (int_b !== ((j == 5) ? 1'b0 : 1'b1))
        $display("FAIL first_tick_c%0d: got %b want %b", j, int_b, (j == 5) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    bus_write(16'hFFFF, 16'h0003); // clear lands at E+9
    @(negedge clk);
    check_cnt++; if (int_b !== 1'b1) $display("FAIL clear_pending: got %b want 1", int_b); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (int_b !== 1'b0) $display("FAIL second_tick: got %b want 0", int_b); else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    bus_write(16'hFFFF, 16'h0003); // clear lands on expiry at E+15
    @(negedge clk);
    check_cnt++; if (int_b !== 1'b0) $display("FAIL clear_vs_expiry: got %b want 0", int_b); else pass_cnt++;
    @(posedge clk); #1;
    access(16'hFFFF, 16'h0000, 1'b0, 1'b0, rd, pat);
    check_cnt++; if (rd !== 16'h0003) $display("FAIL ctrl_read: got %h want 0003", rd); else pass_cnt++;
    bus_write(16'hFFFF, 16'h0002);
    bad = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (int_b !== 1'b1) bad++;
    end
    check_cnt++; if (bad != 0) $display("FAIL disabled_quiet: got %0d low cycles want 0", bad); else pass_cnt++;
    @(posedge clk); #1;
    bus_read(16'hFFFF, rd);
    check_cnt++; if (rd !== 16'h0000) $display("FAIL ctrl_disabled: got %h want 0000", rd); else pass_cnt++;
    bus_write(16'hFFFE, 16'h0003);
    bus_write(16'hFFFF, 16'h0001);
    for (int j = 0; j <= 3; j++) begin
      @(negedge clk);
      check_cnt++;
      if (int_b !== ((j == 3) ? 1'b0 : 1'b1))
        $display("FAIL reload3_c%0d: got %b want %b", j, int_b, (j == 3) ? 1'b0 : 1'b1);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    bus_write(16'hFFFF, 16'h0002);
  endtask
`else
  task automatic test_no_timer();
    logic [15:0] rd; logic [2:0] pat;
    bus_write(16'h0FFF, 16'h0000);
    access(16'hFFFF, 16'h5A5A, 1'b1, 1'b0, rd, pat);
    idle();
    check_cnt++; if (pat !== PAT) $display("FAIL ffff_write_clken: got %b want %b", pat, PAT); else pass_cnt++;
    bus_read(16'hFFFF, rd);
    check_cnt++; if (rd !== 16'h5A5A) $display("FAIL ffff_readback: got %h want 5a5a", rd); else pass_cnt++;
    bus_read(16'h0FFF, rd);
    check_cnt++; if (rd !== 16'h5A5A) $display("FAIL ffff_alias: got %h want 5a5a", rd); else pass_cnt++;
    bus_write(16'hFFFE, 16'h1357);
    bus_read(16'h0FFE, rd);
    check_cnt++; if (rd !== 16'h1357) $display("FAIL fffe_alias: got %h want 1357", rd); else pass_cnt++;
    check_cnt++; if (int_low_seen !== 1'b0) $display("FAIL int_b_idle: got low want always 1"); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_mreq_drop();
`ifdef RESP_IRQ_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
